// File: rtl/icache_sa_if.sv
// Fetch-side and Wishbone-side signal bundle for icache_sa.
// slave = the cache, master = fetch unit plus bus fabric.
interface icache_sa_if #(parameter int ADDR_W = 16);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_ready;
  logic              mem_ack;
  logic [31:0]       mem_data;
  logic              mem_err;
  logic              mem_flush;
  logic              stat_clr;
  logic [15:0]       stat_hit;
  logic [15:0]       stat_miss;
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [1:0]        wb_sel;
  logic [ADDR_W-1:0] wb_adr;
  logic [15:0]       wb_i_dat;
  logic              wb_ack;
  logic              wb_err;

  modport slave (
    input  mem_req, mem_addr, mem_flush, stat_clr, wb_i_dat, wb_ack, wb_err,
    output mem_ready, mem_ack, mem_data, mem_err, stat_hit, stat_miss,
           wb_cyc, wb_stb, wb_we, wb_sel, wb_adr
  );
  modport master (
    output mem_req, mem_addr, mem_flush, stat_clr, wb_i_dat, wb_ack, wb_err,
    input  mem_ready, mem_ack, mem_data, mem_err, stat_hit, stat_miss,
           wb_cyc, wb_stb, wb_we, wb_sel, wb_adr
  );
endinterface

// File: rtl/icache_sa.sv
// 1/2-way set-associative instruction cache with LRU, 16-bit Wishbone line fill,
// bus-error reporting and saturating hit/miss counters.
module icache_sa #(
  parameter int WAYS   = 2,
  parameter int IDX_W  = 5,
  parameter int OFF_W  = 2,
  parameter int ADDR_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst,
  icache_sa_if.slave  bus
);
  localparam int SETS  = 1 << IDX_W;
  localparam int INSTS = 1 << OFF_W;
  localparam int BEATS = 2 * INSTS;
  localparam int TAG_W = ADDR_W - IDX_W - OFF_W;

  typedef enum logic [1:0] {IDLE, LOOKUP, FILL} state_t;

  state_t                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q;
  logic [TAG_W-1:0]        tag_mem   [WAYS][SETS];
  logic [INSTS-1:0][31:0]  data_mem  [WAYS][SETS];
  logic [TAG_W-1:0]        rd_tag_q  [WAYS];
  logic [INSTS-1:0][31:0]  rd_data_q [WAYS];
  logic [WAYS-1:0]         valid_q   [SETS];
  logic [SETS-1:0]         lru_q;
  logic [OFF_W:0]          beat_q;
  logic [BEATS-2:0][15:0]  line_q;
  logic                    vic_q, err_q, fflush_q;
  logic [15:0]             hit_cnt_q, miss_cnt_q;

  logic [IDX_W-1:0]        idx, acc_idx;
  logic [TAG_W-1:0]        tag;
  logic [OFF_W-1:0]        off;
  logic                    accept, beat_ev, last, fill_err, fill_wr;
  logic                    hit, hit_way, vic, vic_found;
  logic                    ready, ack, err, cyc;
  logic [31:0]             data;
  logic [INSTS-1:0][31:0]  fill_line;

  assign idx       = addr_q[IDX_W+OFF_W-1:OFF_W];
  assign tag       = addr_q[ADDR_W-1:IDX_W+OFF_W];
  assign off       = addr_q[OFF_W-1:0];
  assign acc_idx   = bus.mem_addr[IDX_W+OFF_W-1:OFF_W];
  assign accept    = bus.mem_req & ready;
  assign beat_ev   = (state_q == FILL) & (bus.wb_ack | bus.wb_err);
  assign last      = beat_ev & (&beat_q);
  assign fill_err  = err_q | bus.wb_err;
  // A flush on or before the last beat makes the fetched line stale for caching.
  assign fill_wr   = last & ~fill_err & ~fflush_q & ~bus.mem_flush;
  // Last beat bypasses the line register straight from the bus.
  assign fill_line = {bus.wb_i_dat, line_q};

  // Valid bits are flops read live, so a flush at the accept edge forces a miss.
  always_comb begin
    hit       = 1'b0;
    hit_way   = 1'b0;
    vic       = lru_q[idx];
    vic_found = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (valid_q[idx][w] && rd_tag_q[w] == tag) begin
        hit     = 1'b1;
        hit_way = 1'(w);
      end
      if (!vic_found && !valid_q[idx][w]) begin
        vic       = 1'(w);
        vic_found = 1'b1;
      end
    end
    if (WAYS == 1) vic = 1'b0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    ready   = 1'b0;
    ack     = 1'b0;
    err     = 1'b0;
    cyc     = 1'b0;
    data    = '0;
    case (state_q)
      IDLE: begin
        ready = 1'b1;
        if (bus.mem_req) state_d = LOOKUP;
      end
      LOOKUP: begin
        if (hit) begin
          ack     = 1'b1;
          ready   = 1'b1;
          data    = rd_data_q[hit_way][off];
          state_d = bus.mem_req ? LOOKUP : IDLE;
        end else begin
          state_d = FILL;
        end
      end
      FILL: begin
        cyc = 1'b1;
        if (last) begin
          ack     = 1'b1;
          err     = fill_err;
          data    = fill_line[off];
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Array side: synchronous read on accept, line write at a clean fill end.
  always_ff @(posedge i_clk) begin
    if (accept) begin
      addr_q <= bus.mem_addr;
      for (int w = 0; w < WAYS; w++) begin
        rd_tag_q[w]  <= tag_mem[w][acc_idx];
        rd_data_q[w] <= data_mem[w][acc_idx];
      end
    end
    if (beat_ev && !last) line_q[beat_q] <= bus.wb_i_dat;
    if (fill_wr) begin
      tag_mem[vic_q][idx]  <= tag;
      data_mem[vic_q][idx] <= fill_line;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      beat_q   <= '0;
      vic_q    <= 1'b0;
      err_q    <= 1'b0;
      fflush_q <= 1'b0;
      lru_q    <= '0;
      for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
    end else begin
      if (state_q == LOOKUP && !hit) begin
        vic_q    <= vic;
        err_q    <= 1'b0;
        fflush_q <= 1'b0;
        beat_q   <= '0;
      end
      if (beat_ev) begin
        beat_q <= beat_q + 1'b1;
        if (bus.wb_err) err_q <= 1'b1;
      end
      if (state_q == FILL && bus.mem_flush) fflush_q <= 1'b1;
      if (state_q == LOOKUP && hit) lru_q[idx] <= ~hit_way;
      if (fill_wr) begin
        valid_q[idx][vic_q] <= 1'b1;
        lru_q[idx]          <= ~vic_q;
      end
      if (bus.mem_flush) begin
        lru_q <= '0;
        for (int s = 0; s < SETS; s++) valid_q[s] <= '0;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst || bus.stat_clr) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else if (state_q == LOOKUP) begin
      if (hit && hit_cnt_q != 16'hFFFF)   hit_cnt_q  <= hit_cnt_q + 16'd1;
      if (!hit && miss_cnt_q != 16'hFFFF) miss_cnt_q <= miss_cnt_q + 16'd1;
    end
  end

  assign bus.mem_ready = ready;
  assign bus.mem_ack   = ack;
  assign bus.mem_err   = err;
  assign bus.mem_data  = data;
  assign bus.stat_hit  = hit_cnt_q;
  assign bus.stat_miss = miss_cnt_q;
  assign bus.wb_cyc    = cyc;
  assign bus.wb_stb    = cyc;
  assign bus.wb_we     = 1'b0;
  assign bus.wb_sel    = 2'b11;
  assign bus.wb_adr    = {addr_q[ADDR_W-2:OFF_W], beat_q};
endmodule

// File: doc/icache_sa.md
# icache_sa

Parametrised set-associative instruction cache; next generation of the direct-mapped icache. It sits between the fetch unit and the instruction Wishbone bus, and serves 32-bit instructions from 1- or 2-way storage with LRU replacement. Misses fill the line with a 16-bit Wishbone burst. The block adds an explicit ready handshake, bus-error reporting to fetch, and hit/miss statistics counters.

## Interface

**Parameters**
- `WAYS`, default 2: associativity; legal values are 1 or 2.
- `IDX_W`, default 5: set-index width; there are 2^IDX_W sets.
- `OFF_W`, default 2: instruction-offset width; a line holds 2^OFF_W instructions, which is 2^(OFF_W+1) bus beats.
- `ADDR_W`, default 16: instruction-address width. Tag = `addr[ADDR_W-1:IDX_W+OFF_W]`.

**Ports**
- `i_clk`, in, 1: clock.
- `i_rst`, in, 1: reset, synchronous, active-high.
- `mem_req`, in, 1: fetch request; accepted when `mem_req & mem_ready`.
- `mem_addr`, in, ADDR_W: instruction address, sampled on accept.
- `mem_ready`, out, 1: cache can accept a request this cycle.
- `mem_ack`, out, 1: one-cycle pulse, `mem_data` valid.
- `mem_data`, out, 32: instruction; undefined while `mem_ack`=0.
- `mem_err`, out, 1: qualifies `mem_ack`; the burst had a bus error.
- `mem_flush`, in, 1: invalidate the whole cache.
- `stat_clr`, in, 1: clear the statistics counters.
- `stat_hit`, out, 16: saturating hit count.
- `stat_miss`, out, 16: saturating miss count.
- `wb_cyc`, out, 1: Wishbone cycle.
- `wb_stb`, out, 1: Wishbone strobe.
- `wb_we`, out, 1: tied 0.
- `wb_sel`, out, 2: tied 2'b11.
- `wb_adr`, out, ADDR_W: Wishbone halfword address.
- `wb_i_dat`, in, 16: Wishbone read data.
- `wb_ack`, in, 1: Wishbone acknowledge.
- `wb_err`, in, 1: Wishbone error.

## Operation

- **Storage**
  - Per way: tag array, data array and valid bit per set; one LRU bit per set (unused when WAYS=1).
  - Arrays use synchronous read, indexed by the accepted address.
- **Line layout:** instruction i of a line = {beat 2i+1, beat 2i}; beat 0 is fetched first.
- **FSM: IDLE**
  - `mem_ready`=1.
  - On accept, latch the address and go to LOOKUP.
- **FSM: LOOKUP** (one cycle after accept)
  - Compare tags of all ways; hit = valid & tag equal & no flush seen since accept.
  - On hit:
    - assert `mem_ack` with the selected instruction;
    - set LRU to the other way;
    - increment `stat_hit`;
    - `mem_ready`=1, so a same-cycle accept stays in LOOKUP; otherwise go to IDLE.
  - On miss:
    - `mem_ready`=0;
    - choose the victim: the first invalid way (way 0 first), else the way pointed to by LRU;
    - increment `stat_miss`;
    - go to FILL.
- **FSM: FILL**
  - `wb_cyc`=`wb_stb`=1; `wb_adr` = {addr[ADDR_W-2:OFF_W], beat_cnt}, where beat_cnt is OFF_W+1 bits starting at 0.
  - Each `wb_ack|wb_err` stores the beat and increments beat_cnt.
  - Last beat (beat_cnt all ones, acked):
    - `wb_cyc`/`wb_stb` drop the next cycle;
    - `mem_ack`=1 in that same cycle, with the instruction bypassed from the assembled line (last beat taken directly from `wb_i_dat`);
    - write the victim way (tag, data, valid=1) and set LRU to the other way;
    - go to IDLE.
  - `mem_ready`=0 throughout FILL, including the last-beat cycle.
- **Bus error:** if any beat saw `wb_err`, the burst still completes all beats. At the last beat, `mem_ack`=1 and `mem_err`=1, and no array write occurs.
- **Flush**
  - `mem_flush` clears all valid bits and LRU bits at the clock edge.
  - A LOOKUP in the cycle after a flush is forced to miss.
  - A flush during FILL: the burst completes and data is acked, but the line is not written.
  - Flush and accept in the same cycle: flush wins for valid bits, and the request misses.
- **Counters:** cleared by `i_rst` or `stat_clr`; they saturate at 0xFFFF. `stat_clr` together with an event gives 0.

## Timing

- **Reset values:**
  - state IDLE, `mem_ready`=1;
  - `mem_ack`, `mem_err`, `wb_cyc`, `wb_stb` all 0;
  - beat_cnt 0, all valid and LRU bits 0, counters 0.
- **Hit latency:** accept in cycle N, `mem_ack` in N+1. Back-to-back hits sustain one per cycle.
- **Miss:**
  - accept N, LOOKUP N+1, `wb_stb` from N+2;
  - with zero-wait `wb_ack`, `mem_ack` in N+2+2^(OFF_W+1)-1;
  - `mem_ready` returns in the cycle after `mem_ack`.
- **Reset mid-FILL:** `wb_cyc` is 0 the next cycle, no write occurs, and no `mem_ack` is issued.

## Test plan

Configuration is the defaults unless stated otherwise.

1. **Cold miss then hit**
   - Stimulus: reset, then request 0x0010; bus returns 0x1000+k for beat k.
   - Required: `wb_adr` 0x0020..0x0027, `mem_ack` with 0x10011000, `stat_miss`=1.
   - Then request 0x0013: `mem_ack` next cycle with 0x10071006, no `wb_cyc`, `stat_hit`=1.
2. **2-way LRU**
   - Stimulus: request 0x0010 and 0x0090 (both set 4); both miss.
   - Re-request both: both hit.
   - Request 0x0010, then 0x0110: the miss evicts 0x0090.
   - Required: a following 0x0090 misses and 0x0010 hits.
3. **Back-to-back hits**
   - Stimulus: `mem_req` held for 4 cycles over 4 cached addresses.
   - Required: 4 consecutive `mem_ack` pulses, `mem_ready` stays 1, `stat_hit` increases by 4.
4. **Bus error**
   - Stimulus: `wb_err` on beat 3 of a fill at 0x0020.
   - Required: all 8 beats are issued, `mem_ack`=`mem_err`=1 at beat 7, and re-requesting 0x0020 misses again.
5. **Flush**
   - Stimulus A: `mem_flush` during beat 4 of a fill. Required: data is acked and `mem_err`=0; the next request to the same line misses.
   - Stimulus B: flush in the same cycle as a request to a cached line. Required: that request misses.
6. **Reset and saturation**
   - Stimulus: `i_rst` mid-fill. Required: `wb_cyc`=0 next cycle, `mem_ready`=1, and a previously cached line misses.
   - Stimulus: force 0x10000+ hits. Required: `stat_hit` holds 0xFFFF; `stat_clr` sets it to 0.
